// File: rtl/spi_ram.sv
// spi_ram: byte-wide memory behind an SPI slave command stream.
// Each 10-bit command carries a 2-bit opcode and an 8-bit payload:
//   00 load write pointer, 01 write data, 10 load read pointer, 11 read data.
// Write and read pointers are fully independent and optionally auto-increment
// after every data access, wrapping at the top of the memory.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       rd_err
);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1);

  // Storage is deliberately left out of reset so it can map onto block RAM
  // and so contents survive a reset.
  logic [7:0]           mem [0:MEM_DEPTH-1];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 rd_addr_set;

  // Map the 8-bit payload onto the address width, zero-extending or
  // truncating as the ADDR_SIZE parameter requires.
  function automatic logic [ADDR_SIZE-1:0] to_addr(input logic [7:0] b);
    logic [ADDR_SIZE+7:0] ext;
    ext = {{ADDR_SIZE{1'b0}}, b};
    return ext[ADDR_SIZE-1:0];
  endfunction

  // Post-access pointer advance: explicit wrap from the last word to 0,
  // or hold when auto-increment is disabled.
  function automatic logic [ADDR_SIZE-1:0] ptr_next(input logic [ADDR_SIZE-1:0] p);
    if (AUTO_INC == 0) return p;
    if (p == LAST_ADDR) return '0;
    return p + ADDR_ONE;
  endfunction

  // ---- stage p0: command decode (combinational, same cycle as rx_valid) ----
  logic [1:0] op_p0;
  logic [7:0] pay_p0;
  logic       wr_addr_p0;
  logic       wr_data_p0;
  logic       rd_addr_p0;
  logic       rd_fire_p0;
  logic       rd_miss_p0;

  // Qualify each opcode with rx_valid; a read only fires once an address is loaded.
  always_comb begin
    op_p0      = din[9:8];
    pay_p0     = din[7:0];
    wr_addr_p0 = 1'b0;
    wr_data_p0 = 1'b0;
    rd_addr_p0 = 1'b0;
    rd_fire_p0 = 1'b0;
    rd_miss_p0 = 1'b0;
    if (rx_valid) begin
      case (op_p0)
        OP_WR_ADDR: wr_addr_p0 = 1'b1;
        OP_WR_DATA: wr_data_p0 = 1'b1;
        OP_RD_ADDR: rd_addr_p0 = 1'b1;
        OP_RD_DATA: begin
          rd_fire_p0 = rd_addr_set;
          rd_miss_p0 = ~rd_addr_set;
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: registered state and outputs ----

  // Memory write port; no reset so contents persist across rst.
  always_ff @(posedge clk) begin
    if (wr_data_p0) mem[wr_ptr] <= pay_p0;
  end

  // Write pointer: loaded by opcode 00, advanced after each opcode 01.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_addr_p0) begin
      wr_ptr <= to_addr(pay_p0);
    end else if (wr_data_p0) begin
      wr_ptr <= ptr_next(wr_ptr);
    end
  end

  // Read pointer and address-loaded flag: loaded by opcode 10, advanced after each successful read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      rd_addr_set <= 1'b0;
    end else if (rd_addr_p0) begin
      rd_ptr      <= to_addr(pay_p0);
      rd_addr_set <= 1'b1;
    end else if (rd_fire_p0) begin
      rd_ptr      <= ptr_next(rd_ptr);
    end
  end

  // Sticky read error: set by a read with no address loaded, cleared only by opcode 10.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err <= 1'b0;
    end else if (rd_addr_p0) begin
      rd_err <= 1'b0;
    end else if (rd_miss_p0) begin
      rd_err <= 1'b1;
    end
  end

  // Read data and its one-cycle qualifier; dout holds between successful reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= rd_fire_p0;
      if (rd_fire_p0) dout <= mem[rd_ptr];
    end
  end

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8, address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 Parameter AUTO_INC, default 1, when 1 the write/read pointers increment after each data access.
REQ-004 Port clk  input  1  rising-edge clock shared with the SPI slave.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port din  input  10  command word from the SPI slave rx_data; din[9:8] opcode, din[7:0] payload.
REQ-007 Port rx_valid  input  1  din qualifier; one command is consumed per cycle with rx_valid=1.
REQ-008 Port dout  output  8  read data returned to the SPI slave tx_data.
REQ-009 Port tx_valid  output  1  one-cycle pulse qualifying dout.
REQ-010 Port rd_err  output  1  sticky flag: read-data command received with no read address loaded.

Function
REQ-011 Internal state SHALL be wr_ptr[ADDR_SIZE-1:0], rd_ptr[ADDR_SIZE-1:0], rd_addr_set flag, and mem[0:MEM_DEPTH-1] of 8 bits.
REQ-012 All decoding SHALL occur only on rising clk edges with rx_valid=1; with rx_valid=0 no state changes except tx_valid deassertion.
REQ-013 Opcode 00 (write address): wr_ptr <= din[7:0].
REQ-014 Opcode 01 (write data): mem[wr_ptr] <= din[7:0]; if AUTO_INC=1, wr_ptr <= wr_ptr+1, wrapping MEM_DEPTH-1 -> 0.
REQ-015 Opcode 10 (read address): rd_ptr <= din[7:0]; rd_addr_set <= 1; rd_err <= 0.
REQ-016 Opcode 11 with rd_addr_set=1: dout <= mem[rd_ptr] and tx_valid <= 1 on the same edge (tx_valid high the cycle after rx_valid was sampled); if AUTO_INC=1, rd_ptr <= rd_ptr+1 with wrap.
REQ-017 Opcode 11 with rd_addr_set=0: no memory access, dout unchanged, tx_valid stays 0, rd_err <= 1.
REQ-018 tx_valid SHALL be high for exactly one cycle per successful read and 0 otherwise.
REQ-019 dout SHALL hold its last read value until the next successful read.
REQ-020 rx_valid held high on consecutive cycles SHALL be treated as one independent command per cycle; back-to-back 11 commands produce back-to-back tx_valid pulses at consecutive addresses.
REQ-021 A write (01) followed on the next cycle by a read (11) of the same address SHALL return the newly written byte.
REQ-022 rd_err SHALL remain set until reset or the next opcode 10.
REQ-023 Write and read pointers SHALL be independent; opcode 00/01 never alters rd_ptr and vice versa.

Reset
REQ-024 rst=1 SHALL immediately and asynchronously force dout=8'h00, tx_valid=0, rd_err=0, wr_ptr=0, rd_ptr=0, rd_addr_set=0.
REQ-025 Memory contents SHALL NOT be cleared by reset; reads of unwritten locations are undefined.
REQ-026 Reset asserted mid-sequence SHALL discard the pending command; after release, opcode 11 without a prior 10 sets rd_err.
REQ-027 Operation SHALL resume on the first rising clk edge after rst deasserts.

Verification
REQ-028 Write 00_0x10, 01_0xA5, then 10_0x10, 11_xx -> tx_valid pulses one cycle after the 11 command with dout=0xA5.
REQ-029 AUTO_INC=1: 00_0xFF, 01_0x11, 01_0x22, then 10_0xFF, 11, 11 -> dout 0x11 then 0x22 (address wrapped to 0x00), two consecutive tx_valid pulses.
REQ-030 After reset, send 11_0x00 -> tx_valid=0, dout=0x00, rd_err=1; then 10_0x05 -> rd_err=0.
REQ-031 rx_valid=0 with din toggling randomly for 20 cycles -> no pointer, memory, dout or tx_valid change.
REQ-032 Assert rst between a 10 and an 11 command -> all outputs 0 asynchronously; subsequent 11 -> rd_err=1, no tx_valid.
REQ-033 Connected to the SPI slave: full SPI transaction write-address, write-data, read-address, read-data on MOSI -> MISO shifts out the written byte MSB first.
